// File: rtl/nyan_sequencer.sv
// Per-frame sprite animation sequencer: on each accepted vblank it steps position,
// animation frame and rainbow phase in shadow registers, then commits them together.
module nyan_sequencer #(
  parameter int unsigned NUM_FRAMES = 2,
  parameter int unsigned FRAME_DIV  = 16,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned LEFT_INIT  = 128,
  parameter int unsigned TOP_INIT   = 128,
  parameter int unsigned TOP_MIN    = 120,
  parameter int unsigned TOP_MAX    = 136,
  parameter int unsigned BOB_STEP   = 8,
  parameter int unsigned X_STEP     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic scroll_en,
  input  logic vblank_start,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] anim_frame,
  output logic [9:0] sprite_left,
  output logic [9:0] sprite_top,
  output logic rainbow_phase,
  output logic update_strobe,
  output logic overrun
);

  localparam int unsigned AW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_BOB, S_COMMIT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DW-1:0]  r_div;
  logic           r_step;
  logic           r_dir_up;
  logic [AW-1:0]  r_sh_anim;
  logic [9:0]     r_sh_left;
  logic [9:0]     r_sh_top;
  logic           r_sh_phase;

  logic               w_accept;
  logic               w_div_last;
  logic [10:0]        w_left_sum;
  logic [10:0]        w_left_wrap;
  logic signed [11:0] w_top_dn;
  logic signed [11:0] w_top_up;
  logic [AW-1:0]      w_anim_nxt;

  assign w_accept    = (r_state == S_IDLE) && vblank_start && enable;
  assign w_div_last  = (r_div == DW'(FRAME_DIV - 1));
  assign w_left_sum  = 11'(r_sh_left) + 11'(X_STEP);
  assign w_left_wrap = (w_left_sum >= 11'(SCREEN_W)) ? (w_left_sum - 11'(SCREEN_W)) : w_left_sum;
  // Widened signed arithmetic so the upward bob can never wrap below zero.
  assign w_top_dn    = $signed({2'b00, r_sh_top}) + $signed(12'(BOB_STEP));
  assign w_top_up    = $signed({2'b00, r_sh_top}) - $signed(12'(BOB_STEP));
  assign w_anim_nxt  = (r_sh_anim == AW'(NUM_FRAMES - 1)) ? '0 : (r_sh_anim + AW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_CALC;
      S_CALC:   w_state_nxt = S_BOB;
      S_BOB:    w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_step        <= 1'b0;
      r_dir_up      <= 1'b0;
      r_sh_anim     <= '0;
      r_sh_left     <= 10'(LEFT_INIT);
      r_sh_top      <= 10'(TOP_INIT);
      r_sh_phase    <= 1'b0;
      anim_frame    <= '0;
      sprite_left   <= 10'(LEFT_INIT);
      sprite_top    <= 10'(TOP_INIT);
      rainbow_phase <= 1'b0;
      update_strobe <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      update_strobe <= (r_state == S_COMMIT);
      if (vblank_start && (r_state != S_IDLE)) overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh_anim  <= anim_frame;
            r_sh_left  <= sprite_left;
            r_sh_top   <= sprite_top;
            r_sh_phase <= rainbow_phase;
          end
        end
        S_CALC: begin
          r_step <= w_div_last;
          r_div  <= w_div_last ? '0 : (r_div + DW'(1));
          if (scroll_en) r_sh_left <= 10'(w_left_wrap);
        end
        S_BOB: begin
          if (r_step) begin
            r_sh_anim  <= w_anim_nxt;
            r_sh_phase <= ~r_sh_phase;
            if (!r_dir_up) begin
              if (w_top_dn >= $signed(12'(TOP_MAX))) begin
                r_sh_top <= 10'(TOP_MAX);
                r_dir_up <= 1'b1;
              end else begin
                r_sh_top <= 10'(w_top_dn);
              end
            end else begin
              if (w_top_up <= $signed(12'(TOP_MIN))) begin
                r_sh_top <= 10'(TOP_MIN);
                r_dir_up <= 1'b0;
              end else begin
                r_sh_top <= 10'(w_top_up);
              end
            end
          end
        end
        S_COMMIT: begin
          anim_frame    <= r_sh_anim;
          sprite_left   <= r_sh_left;
          sprite_top    <= r_sh_top;
          rainbow_phase <= r_sh_phase;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nyan_sequencer.sv
// Directed self-checking bench for nyan_sequencer with default parameters.
module tb_nyan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       scroll_en;
  logic       vblank_start;
  logic [0:0] anim_frame;
  logic [9:0] sprite_left;
  logic [9:0] sprite_top;
  logic       rainbow_phase;
  logic       update_strobe;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Expected-state tracking
  int m_cnt, m_anim, m_top, m_left, m_phase, m_ovr;
  bit m_up;

  nyan_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .scroll_en     (scroll_en),
    .vblank_start  (vblank_start),
    .anim_frame    (anim_frame),
    .sprite_left   (sprite_left),
    .sprite_top    (sprite_top),
    .rainbow_phase (rainbow_phase),
    .update_strobe (update_strobe),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_anim = 0; m_top = 128; m_left = 128; m_phase = 0; m_ovr = 0; m_up = 1'b0;
  endtask

  task automatic model_step(input bit scr);
    if (scr) m_left = (m_left + 4 >= 640) ? m_left + 4 - 640 : m_left + 4;
    m_cnt++;
    if (m_cnt == 16) begin
      m_cnt   = 0;
      m_anim  = 1 - m_anim;
      m_phase = 1 - m_phase;
      if (!m_up) begin
        m_top = m_top + 8;
        if (m_top >= 136) begin m_top = 136; m_up = 1'b1; end
      end else begin
        m_top = m_top - 8;
        if (m_top <= 120) begin m_top = 120; m_up = 1'b0; end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".anim"},    32'(anim_frame),    32'(m_anim));
    check({tag, ".left"},    32'(sprite_left),   32'(m_left));
    check({tag, ".top"},     32'(sprite_top),    32'(m_top));
    check({tag, ".phase"},   32'(rainbow_phase), 32'(m_phase));
    check({tag, ".overrun"}, 32'(overrun),       32'(m_ovr));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  // Accepted pulse: strobe and new values must appear exactly on the 4th edge
  task automatic pulse_commit(input string tag);
    @(negedge clk);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    check({tag, ".nostb0"}, 32'(update_strobe), 32'd0);
    tick();
    check({tag, ".nostb1"}, 32'(update_strobe), 32'd0);
    tick();
    check({tag, ".nostb2"}, 32'(update_strobe), 32'd0);
    check({tag, ".hold"},   32'(sprite_left),   32'(m_left));
    tick();
    check({tag, ".stb"},    32'(update_strobe), 32'd1);
    model_step(scroll_en);
    check_outputs(tag);
    tick();
    check({tag, ".stbend"}, 32'(update_strobe), 32'd0);
    repeat (5) tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; scroll_en = 1'b0; vblank_start = 1'b0;
    do_reset();
    check("rst.strobe", 32'(update_strobe), 32'd0);
    check_outputs("rst");

    // Frozen: pulses with enable low are ignored entirely
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vblank_start = 1'b1;
      tick();
      vblank_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
        tick();
        check("frozen.strobe", 32'(update_strobe), 32'd0);
      end
    end
    check_outputs("frozen");

    // First 15 frames keep initial frame/top/phase, 16th steps them
    enable = 1'b1;
    for (int i = 0; i < 15; i++) pulse_commit("pre");
    check("f15.anim", 32'(anim_frame), 32'd0);
    check("f15.top",  32'(sprite_top), 32'd128);
    pulse_commit("f16");
    check("f16.anim",  32'(anim_frame),    32'd1);
    check("f16.top",   32'(sprite_top),    32'd136);
    check("f16.phase", 32'(rainbow_phase), 32'd1);

    // Bob sequence 128,120,128,136 on subsequent steps
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 16; i++) pulse_commit("bob");
    check("bob.top",  32'(sprite_top), 32'd136);
    check("bob.anim", 32'(anim_frame), 32'd1);

    // Scroll to 636, then wrap to 0, 4, 8
    scroll_en = 1'b1;
    while (m_left != 636) pulse_commit("scr");
    check("scr.at636", 32'(sprite_left), 32'd636);
    pulse_commit("wrap0");
    check("wrap.l0", 32'(sprite_left), 32'd0);
    pulse_commit("wrap4");
    check("wrap.l4", 32'(sprite_left), 32'd4);
    pulse_commit("wrap8");
    check("wrap.l8", 32'(sprite_left), 32'd8);
    scroll_en = 1'b0;
    pulse_commit("noscr");
    pulse_commit("noscr");
    check("noscr.l8", 32'(sprite_left), 32'd8);

    // Overrun: second pulse while busy is dropped
    @(negedge clk);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    tick();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    check("ovr.nostb", 32'(update_strobe), 32'd0);
    tick();
    check("ovr.stb", 32'(update_strobe), 32'd1);
    model_step(1'b0);
    m_ovr = 1;
    check_outputs("ovr");
    for (int k = 0; k < 8; k++) begin
      tick();
      check("ovr.single", 32'(update_strobe), 32'd0);
    end
    pulse_commit("ovr.sticky");

    // Reset while in BOB aborts without strobe
    @(negedge clk);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("abort.strobe", 32'(update_strobe), 32'd0);
    check_outputs("abort");
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort.nostb", 32'(update_strobe), 32'd0);
    end
    pulse_commit("after");
    check("after.left", 32'(sprite_left), 32'd128);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nyan_sequencer.md
Name: nyan_sequencer

Overview:
- Per-frame animation controller for the VGA sprite renderer.
- Once per frame, on a vertical-blank pulse from the timing logic, it computes the next sprite position, animation frame index and rainbow phase.
- It commits all of them atomically, so the renderer only sees values change outside active video.
- It replaces the free-running frame counter used for frame selection and adds vertical bobbing and horizontal scrolling.

Parameters:
- NUM_FRAMES, 2, number of bitmap animation frames; anim_frame cycles 0..NUM_FRAMES-1.
- FRAME_DIV, 16, accepted vblanks per animation step (must be ≥1).
- SCREEN_W, 640, horizontal wrap modulus for sprite_left.
- LEFT_INIT, 128, reset value of sprite_left.
- TOP_INIT, 128, reset value of sprite_top.
- TOP_MIN, 120, lower bob limit; TOP_MIN ≤ TOP_INIT ≤ TOP_MAX.
- TOP_MAX, 136, upper bob limit.
- BOB_STEP, 8, sprite_top change per animation step.
- X_STEP, 4, sprite_left change per accepted vblank while scrolling (must be < SCREEN_W).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  high = vblank pulses accepted; low = sequencer frozen.
- scroll_en  in  1  high = sprite_left advances each accepted frame.
- vblank_start  in  1  single-cycle pulse at start of vertical blank.
- anim_frame  out  $clog2(NUM_FRAMES) (min 1)  bitmap frame select.
- sprite_left  out  10  sprite X origin in pixels.
- sprite_top  out  10  sprite Y origin in pixels.
- rainbow_phase  out  1  trail colour phase; toggles each animation step.
- update_strobe  out  1  one-cycle pulse when new values are committed.
- overrun  out  1  sticky; a vblank_start arrived while busy.

Behaviour:
- Synchronous active-low reset, all registers. Reset values:
  - anim_frame=0, sprite_left=LEFT_INIT, sprite_top=TOP_INIT.
  - rainbow_phase=0, update_strobe=0, overrun=0.
  - div_cnt=0, bob_dir=down (increasing top), state=IDLE.
- Reset asserted in any state aborts the computation. Shadow values are discarded and no strobe is issued.
- FSM: IDLE -> CALC -> BOB -> COMMIT -> IDLE, one cycle per state.
- IDLE:
  - vblank_start=1 and enable=1: go to CALC and copy the output registers into shadow registers.
  - vblank_start=1 and enable=0: ignored, no overrun.
- CALC:
  - If div_cnt==FRAME_DIV-1: div_cnt<=0 and set step flag. Otherwise div_cnt<=div_cnt+1 and clear step flag.
  - If scroll_en: shadow_left <= shadow_left+X_STEP; if the result is ≥ SCREEN_W, subtract SCREEN_W. Compute at 11 bits, no truncation before compare.
- BOB (only when step flag set; otherwise shadows unchanged):
  - shadow_anim <= (shadow_anim+1) mod NUM_FRAMES.
  - shadow_phase toggles.
  - Direction down: top+BOB_STEP. If the result is ≥ TOP_MAX, clamp to TOP_MAX and set bob_dir=up.
  - Direction up: top-BOB_STEP. If the result is ≤ TOP_MIN, clamp to TOP_MIN and set bob_dir=down.
  - Evaluate the up case signed/widened so no underflow wraps.
- COMMIT: all shadows are written to the outputs on the same edge and update_strobe=1 for this one cycle.
- Latency: outputs and strobe change at the 4th rising edge after the edge that samples vblank_start (IDLE, CALC, BOB, COMMIT). Outputs are otherwise held constant.
- vblank_start=1 while the state is not IDLE: pulse dropped, overrun<=1 (sticky until reset), current computation unaffected.
- enable deasserted mid-computation: the sequence completes and commits. enable is only sampled in IDLE.
- scroll_en is sampled in CALC only.
- NUM_FRAMES=1: anim_frame is held at 0.

Test Plan:
- Reset, then 15 vblank pulses spaced ≥10 cycles apart -> 15 strobes; anim_frame=0, sprite_top=128, rainbow_phase=0. 16th pulse -> anim_frame=1, top=136, phase=1, bob_dir=up.
- Continue 16-frame steps -> top sequence 136,128,120,128,136; anim_frame alternates 0/1; strobe occurs exactly 4 edges after each pulse.
- scroll_en=1, X_STEP=4, start at left 636 -> next commit left=0. Then 4, 8 on following commits. scroll_en=0 -> left frozen.
- enable=0 with 20 pulses -> no strobe, all outputs at reset values, overrun=0.
- Second pulse 2 cycles after the first -> single strobe, overrun=1 and remaining 1 until rst_n=0.
- rst_n=0 asserted in BOB state -> next edge: all outputs at reset values, no strobe; next pulse produces a normal commit.
